// File: rtl/lsu_subword.sv
// lsu_subword: turns byte/halfword/word loads and stores into whole-word
// accesses on a single-port data memory. Sub-word stores use a read phase
// followed by a write phase. Load data is sign- or zero-extended. Misaligned
// and illegal-width requests are answered without touching memory.
module lsu_subword #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_illegal,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_buf_q;
   logic        mis_q;
   logic        ill_q;

   logic        accept_s;
   logic        ill_s;
   logic        mis_s;
   logic        unused_addr_s;

   // Loads accept b/h/w/bu/hu; stores accept only b/h/w.
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      logic r;
      if (we) begin
         r = (f3 > 3'b010);
      end else begin
         r = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return r;
   endfunction

   // Halfwords need even addresses, words need 4-byte alignment.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic r;
      case (f3[1:0])
         2'b01:   r = a[0];
         2'b10:   r = (a != 2'b00);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Pick the addressed byte/half out of the word and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h000000, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0000, h};
         3'b010:  r = w;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Overlay the store data onto the previously read word.
   function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] a);
      logic [31:0] r;
      r = old;
      case (f3[1:0])
         2'b00:   r[8*a +: 8] = wd[7:0];
         2'b01: begin
            if (a[1]) begin
               r[31:16] = wd[15:0];
            end else begin
               r[15:0] = wd[15:0];
            end
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   assign accept_s      = req_valid && req_ready;
   assign ill_s         = is_illegal(req_we, req_funct3);
   assign mis_s         = !ill_s && is_misaligned(req_funct3, req_addr[1:0]);
   // Address bits above the memory size alias and are deliberately ignored.
   assign unused_addr_s = ^req_addr[31:ADDR_W+2];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch on accept, read buffer capture in READ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
         rd_buf_q <= 32'h0000_0000;
         mis_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         if (accept_s) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            mis_q    <= mis_s;
            ill_q    <= ill_s;
         end
         if (state_q == READ) begin
            rd_buf_q <= mem_rdata;
         end
      end
   end

   // Next-state logic; errors skip memory entirely, sw skips the read phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!accept_s) begin
               state_d = IDLE;
            end else if (ill_s || mis_s) begin
               state_d = RESP;
            end else if (req_we && (req_funct3 == 3'b010)) begin
               state_d = WRITE;
            end else begin
               state_d = READ;
            end
         end
         READ: begin
            if (we_q) begin
               state_d = WRITE;
            end else begin
               state_d = RESP;
            end
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state so reset removes mem_we immediately.
   always_comb begin
      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = 32'h0000_0000;
      resp_misaligned = 1'b0;
      resp_illegal    = 1'b0;
      mem_addr        = addr_q[ADDR_W+1:2];
      mem_we          = 1'b0;
      mem_wdata       = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            mem_addr  = {ADDR_W{1'b0}};
         end
         READ: begin
            mem_we = 1'b0;
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_wdata = merge_store(rd_buf_q, wdata_q, funct3_q, addr_q[1:0]);
         end
         RESP: begin
            resp_valid      = 1'b1;
            resp_misaligned = mis_q;
            resp_illegal    = ill_q;
            if (!we_q && !mis_q && !ill_q) begin
               resp_rdata = load_extend(rd_buf_q, funct3_q, addr_q[1:0]);
            end else begin
               resp_rdata = 32'h0000_0000;
            end
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a behavioural 64-word data memory.
module tb_lsu_subword;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic        resp_illegal;
   logic [5:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_wdata;

   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   lsu_subword #(.ADDR_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      logic        exp_ill;
      int          exp_lat;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One request, observed over cycles 1..7 after the accept edge.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int rc, output int np,
                         output logic [31:0] rd, output logic mis, output logic ill,
                         output logic [7:0] wem, output logic [31:0] wdat,
                         output logic [5:0] a1);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      rc = -1; np = 0; rd = 32'h0; mis = 1'b0; ill = 1'b0; wem = 8'h00; wdat = 32'h0; a1 = 6'h0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 1'b0;
            a1 = mem_addr;
         end
         if (resp_valid) begin
            np++;
            if (rc < 0) begin
               rc = k; rd = resp_rdata; mis = resp_misaligned; ill = resp_illegal;
            end
         end
         if (mem_we) begin
            wem[k] = 1'b1;
            wdat = mem_wdata;
         end
      end
   endtask

   initial begin
      int          rc, np;
      logic [31:0] rd, wdat;
      logic        mis, ill;
      logic [7:0]  wem;
      logic [5:0]  a1;
      logic [31:0] rdy_v, rsp_v, rdat [9];

      tbl[0] = '{"lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 1'b0, 2};
      tbl[1] = '{"lb_11",   1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0, 2};
      tbl[2] = '{"lbu_13",  1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 1'b0, 2};
      tbl[3] = '{"lh_12",   1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 1'b0, 2};
      tbl[4] = '{"lhu_10",  1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 1'b0, 2};
      tbl[5] = '{"sh_11",   1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1'b0, 1};
      tbl[6] = '{"lw_0e",   1'b0, 3'b010, 32'h0E, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      tbl[7] = '{"ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1};
      tbl[8] = '{"st_f100", 1'b1, 3'b100, 32'h10, 32'h5A, 32'h0, 1'b0, 1'b1, 1};

      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899AABB;
      mem[5] = 32'h01234567;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      #12;
      check("rst_ready",  {31'h0, req_ready},  32'h1);
      check("rst_rvalid", {31'h0, resp_valid}, 32'h0);
      check("rst_rdata",  resp_rdata,          32'h0);
      check("rst_flags",  {30'h0, resp_misaligned, resp_illegal}, 32'h0);
      check("rst_we",     {31'h0, mem_we},     32'h0);
      check("rst_maddr",  {26'h0, mem_addr},   32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Loads and error responses from the table.
      for (int i = 0; i < 9; i++) begin
         do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rc, np, rd, mis, ill, wem, wdat, a1);
         check({tbl[i].name, "_lat"},   rc, tbl[i].exp_lat);
         check({tbl[i].name, "_npls"},  np, 1);
         check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
         check({tbl[i].name, "_flags"}, {30'h0, mis, ill}, {30'h0, tbl[i].exp_mis, tbl[i].exp_ill});
         check({tbl[i].name, "_we"},    {24'h0, wem}, 32'h0);
         check({tbl[i].name, "_word"},  mem[4], 32'h8899AABB);
         if (tbl[i].exp_lat == 2) check({tbl[i].name, "_maddr"}, {26'h0, a1}, 32'h4);
      end

      // sb: read-modify-write of byte lane 2.
      do_req(1'b1, 3'b000, 32'h12, 32'h12345677, rc, np, rd, mis, ill, wem, wdat, a1);
      check("sb_lat",   rc, 3);
      check("sb_npls",  np, 1);
      check("sb_wemask", {24'h0, wem}, 32'h4);
      check("sb_wdata", wdat, 32'h8877AABB);
      check("sb_rdata", rd, 32'h0);
      check("sb_flags", {30'h0, mis, ill}, 32'h0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rc, np, rd, mis, ill, wem, wdat, a1);
      check("sb_lw_back", rd, 32'h8877AABB);

      // sh: lower halfword.
      do_req(1'b1, 3'b001, 32'h10, 32'h0000CAFE, rc, np, rd, mis, ill, wem, wdat, a1);
      check("sh_lat",    rc, 3);
      check("sh_wemask", {24'h0, wem}, 32'h4);
      check("sh_word",   mem[4], 32'h8877CAFE);

      // sw: no read phase.
      do_req(1'b1, 3'b010, 32'h18, 32'hDEADBEEF, rc, np, rd, mis, ill, wem, wdat, a1);
      check("sw_lat",    rc, 2);
      check("sw_wemask", {24'h0, wem}, 32'h2);
      check("sw_word",   mem[6], 32'hDEADBEEF);

      // Back-to-back lw with req_valid held high.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      rdy_v = 32'h0; rsp_v = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         rdy_v[k] = req_ready;
         rsp_v[k] = resp_valid;
         rdat[k]  = resp_rdata;
         if (k == 1) req_addr = 32'h14;
         if (k == 5) req_valid = 1'b0;
      end
      check("b2b_ready", rdy_v[3:1], 3'b100);
      check("b2b_pulses", rsp_v[8:1], 8'b0001_0010);
      check("b2b_data1", rdat[2], 32'h8877CAFE);
      check("b2b_data2", rdat[5], 32'h01234567);

      // Reset during the WRITE cycle of an sb.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = 32'hEE;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      check("rstw_we_before", {31'h0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rstw_we_after", {31'h0, mem_we},     32'h0);
      check("rstw_ready",    {31'h0, req_ready},  32'h1);
      check("rstw_rvalid",   {31'h0, resp_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      np = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (resp_valid) np++;
      end
      check("rstw_no_resp", np, 0);
      check("rstw_word", mem[4], 32'h8877CAFE);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rc, np, rd, mis, ill, wem, wdat, a1);
      check("rstw_lw", rd, 32'h8877CAFE);
      check("rstw_lw_lat", rc, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit that sits directly upstream of the word-wide single-port data memory in the single-cycle core.
- Converts core byte/halfword/word loads and stores (RV32I funct3 encodings) into word accesses.
- Sign- or zero-extends load data.
- Performs two-phase read-modify-write for sb/sh, because the data memory has one write enable and no byte lanes.
- Flags misaligned and illegal-width requests without touching memory.

Parameters:
ADDR_W, 6, data memory word-index width (64 words); mem_addr = req_addr[ADDR_W+1:2], upper address bits ignored (aliasing).

Ports:
clk  in  1  clock, same clock as the ctrl bus
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse, request complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_misaligned  out  1  valid with resp_valid
resp_illegal  out  1  valid with resp_valid
mem_addr  out  ADDR_W  word index to data memory
mem_rdata  in  32  combinational read data from data memory
mem_we  out  1  data memory write enable (memory writes on posedge clk)
mem_wdata  out  32  data memory write data

Behaviour:
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE; all latched request fields and rd_buf = 0.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp flags=0; mem_we=0.
  - mem_we is decoded from state, so asserting reset during WRITE suppresses that cycle's write.
- Accept: req_valid && req_ready at a posedge latches we, funct3, addr, wdata.
- req_ready=0 in every state except IDLE. A request held during busy is accepted on the first IDLE edge.
- States: IDLE, READ, WRITE, RESP.
- Transitions from IDLE on accept:
  - Illegal → RESP. Illegal = load funct3 in {011,110,111} or store funct3 > 010.
  - Misaligned → RESP. Misaligned = h/hu with addr[0]=1, or w with addr[1:0]≠0. Illegal is checked first.
  - sw → WRITE.
  - Any load, sb or sh → READ.
- READ: mem_addr=latched index; rd_buf <= mem_rdata. Next state is WRITE for sb/sh, RESP for loads.
- WRITE: mem_we=1 for exactly this cycle.
  - mem_wdata for sw: latched wdata.
  - mem_wdata for sb: rd_buf with byte lane addr[1:0] replaced by wdata[7:0].
  - mem_wdata for sh: rd_buf with halfword lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: resp_valid=1 for one cycle with resp fields; then IDLE. No response backpressure.
- Load extension from rd_buf:
  - lb/lbu: byte at addr[1:0], sign-/zero-extended.
  - lh/lhu: half at addr[1], sign-/zero-extended.
  - lw: full word.
- Latency, counted from the accept edge as cycle 0; resp_valid is high in:
  - cycle 1 for error responses (misaligned or illegal);
  - cycle 2 for loads and sw;
  - cycle 3 for sb/sh.
- Errors: mem_we never asserted; resp_rdata=0; exactly one flag set.
- mem_addr is held at the latched index outside IDLE. In IDLE it is 0.
- mem_wdata=0 when not in WRITE.

Test Plan:
1. Preload word 4 = 0x8899AABB; lw addr 0x10 → resp_valid in cycle 2, resp_rdata=0x8899AABB, flags 0, mem_we never 1.
2. Same preload:
   - lb 0x11 → 0xFFFFFFAA.
   - lbu 0x13 → 0x00000088.
   - lh 0x12 → 0xFFFF8899.
   - lhu 0x10 → 0x0000AABB.
3. sb 0x12, wdata 0x12345677 → mem_we high only in cycle 2 with mem_wdata=0x8877AABB; resp in cycle 3; a follow-up lw 0x10 returns 0x8877AABB. Then sh 0x10, wdata 0xCAFE → word 0x8877CAFE.
4. Misaligned and illegal:
   - sh 0x11 → resp cycle 1, resp_misaligned=1, resp_rdata=0, word unchanged.
   - lw 0x0E → resp_misaligned=1.
   - Load funct3=011 → resp_illegal=1.
   - Store funct3=100 → resp_illegal=1.
5. req_valid held high with two back-to-back lw requests → req_ready low in cycles 1-2; second request accepted at the edge after RESP; each produces exactly one resp_valid pulse.
6. sb in progress, rst_n driven low during the WRITE cycle → mem_we falls immediately, memory word unchanged, req_ready=1, no resp_valid; after rst_n release a new lw returns the original data.
